ate_strobe_capture: RTL and testbench
=====================================

ATE_STROBE_CAPTURE -- requirements
Module: ate_strobe_capture

Interface
REQ-001 Parameter DATA_W, default 8, DQ/data width in bits.
REQ-002 Parameter WIN_W, default 5, width of STRB_BACK/STRB_FRONT; history depth HIST_DEPTH = 2**(WIN_W+1).
REQ-003 Parameter BUF_DEPTH, default 32, capture FIFO depth (power of 2); CNT_W = $clog2(BUF_DEPTH)+1.
REQ-004 Timing is one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 DQ  in  DATA_W  sampled data bus.
REQ-008 DQ_VALID  in  1  DQ valid this cycle.
REQ-009 STRB  in  1  capture request pulse.
REQ-010 STRB_BACK, STRB_FRONT  in  WIN_W  past/future valid samples to include.
REQ-011 MODE  in  1  0 = capture only, 1 = capture and compare.
REQ-012 EXP_DATA, MASK  in  DATA_W  expected value and compare mask (1 = bit checked).
REQ-013 CLR  in  1  clears FIFO, OVF, FAIL, FAIL_CNT, STRB_MISS.
REQ-014 RD_EN  in  1  pop capture FIFO.
REQ-015 RD_DATA  out  DATA_W  popped entry; RD_VALID  out  1  RD_DATA valid.
REQ-016 BUSY  out  1  window in progress; SAMP_CNT  out  CNT_W  FIFO occupancy.
REQ-017 OVF, FAIL, STRB_MISS  out  1  sticky flags; FAIL_CNT  out  16  mismatch count.

Function
REQ-018 History ring (HIST_DEPTH x DATA_W) SHALL write DQ on every DQ_VALID cycle, in all states.
REQ-019 FSM states IDLE, WAIT, COPY; IDLE + STRB -> WAIT, latching BACK, FRONT, EXP_DATA, MASK, MODE.
REQ-020 Anchor = first valid sample at or after the STRB cycle; WAIT counts valid samples, anchor included, and goes to COPY the cycle after the (FRONT+1)-th.
REQ-021 COPY SHALL push N = BACK+FRONT+1 entries, oldest first, starting at history index wp-N (wp after last write), one per cycle, then return to IDLE.
REQ-022 Ring read SHALL precede write in the same cycle, so concurrent writes never corrupt unread window entries (N <= HIST_DEPTH-1 by construction).
REQ-023 Entries older than reset SHALL read as zero.
REQ-024 STRB while not IDLE SHALL be ignored and set STRB_MISS.
REQ-025 Push into full FIFO SHALL drop the entry and set OVF; simultaneous push and pop when full SHALL succeed.
REQ-026 RD_EN with FIFO non-empty SHALL give RD_DATA/RD_VALID the next cycle; RD_EN when empty SHALL be ignored, RD_VALID = 0.
REQ-027 MODE=1: each pushed entry with ((entry ^ EXP) & MASK) != 0 SHALL set FAIL and increment FAIL_CNT, saturating at 16'hFFFF; dropped entries are still compared.
REQ-028 BUSY = 1 in WAIT and COPY.
REQ-029 CLR SHALL abort any window to IDLE; RST has priority over CLR; CLR has priority over a same-cycle push or pop.

Reset
REQ-030 RST: FSM IDLE, history zeroed, FIFO empty, SAMP_CNT = 0, RD_DATA = 0, RD_VALID = 0, BUSY = 0, OVF = FAIL = STRB_MISS = 0, FAIL_CNT = 0.
REQ-031 RST mid-window SHALL discard the window without pushing.

Structure
REQ-032 Shared package SHALL hold FSM state enum, default parameter values, and the FAIL_CNT width constant.
REQ-033 Capture FIFO SHALL be sub-module ate_cap_fifo (param DATA_W, DEPTH; push/pop/full/empty/count).

Verification
REQ-034 DQ = 1..20 valid each cycle; STRB at the DQ=10 cycle, BACK = 2, FRONT = 3 -> FIFO holds 8,9,10,11,12,13; BUSY high 4 cycles then 6 COPY cycles.
REQ-035 Pre-reset gap: STRB on the 2nd valid sample after RST, BACK = 5, FRONT = 0 -> 0,0,0,0,s1,s2.
REQ-036 BUF_DEPTH = 32, windows of 31 then 31 entries, no reads -> SAMP_CNT = 32, OVF = 1, first 32 entries intact.
REQ-037 MODE = 1, EXP = 8'hA5, MASK = 8'hF0, DQ = A0,A5,B5 window -> FAIL = 1, FAIL_CNT = 1.
REQ-038 Second STRB during WAIT -> STRB_MISS = 1, single window captured; CLR during COPY -> IDLE, SAMP_CNT = 0.
REQ-039 DQ_VALID toggling 1,0,1,0 with FRONT = 2 -> WAIT spans 3 valid samples (5 cycles), entries contiguous.

Source files
------------

// File: rtl/ate_strobe_capture_pkg.sv
// Shared definitions for the ATE strobe capture block: FSM encoding,
// default parameter values and the mismatch counter width.
package ate_strobe_capture_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_WIN_W     = 5;
  localparam int DEF_BUF_DEPTH = 32;
  localparam int FAIL_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_COPY = 2'd2
  } cap_state_e;

endpackage

// File: rtl/ate_cap_fifo.sv
// Capture FIFO: registered read port, push succeeds when full if a pop
// happens in the same cycle, clr empties the queue.
module ate_cap_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= do_pop;
      if (do_pop) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ate_strobe_capture.sv
// Strobe-triggered window capture: a history ring of valid DQ samples is
// copied around each strobe (BACK past, FRONT future) into a FIFO, with
// optional masked compare against an expected value.
module ate_strobe_capture
  import ate_strobe_capture_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  localparam int HIST_DEPTH = 2 ** (WIN_W + 1),
  localparam int CNT_W      = $clog2(BUF_DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     DQ,
  input  logic                  DQ_VALID,
  input  logic                  STRB,
  input  logic [WIN_W-1:0]      STRB_BACK,
  input  logic [WIN_W-1:0]      STRB_FRONT,
  input  logic                  MODE,
  input  logic [DATA_W-1:0]     EXP_DATA,
  input  logic [DATA_W-1:0]     MASK,
  input  logic                  CLR,
  input  logic                  RD_EN,
  output logic [DATA_W-1:0]     RD_DATA,
  output logic                  RD_VALID,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      SAMP_CNT,
  output logic                  OVF,
  output logic                  FAIL,
  output logic                  STRB_MISS,
  output logic [FAIL_CNT_W-1:0] FAIL_CNT,
  output cap_state_e            DBG_STATE
);

  localparam int PTR_W = WIN_W + 1;

  logic [DATA_W-1:0] hist [HIST_DEPTH];
  logic [PTR_W-1:0]  wp;

  cap_state_e        state;
  cap_state_e        state_nx;
  logic [PTR_W-1:0]  vcnt;
  logic [PTR_W-1:0]  front_tgt_q;
  logic [PTR_W-1:0]  win_len_q;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  left;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] mask_q;
  logic              mode_q;

  logic [PTR_W-1:0]  win_len_in;
  logic [PTR_W-1:0]  front_tgt_in;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              mismatch;
  logic              fifo_full;
  logic              fifo_empty;

  assign win_len_in   = PTR_W'(STRB_BACK) + PTR_W'(STRB_FRONT) + PTR_W'(1);
  assign front_tgt_in = PTR_W'(STRB_FRONT) + PTR_W'(1);

  // Ring keeps recording during a window; the copy reads the old contents
  // combinationally before the same-edge write lands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else if (DQ_VALID) begin
      hist[wp] <= DQ;
      wp       <= wp + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (STRB) state_nx = ST_WAIT;
      ST_WAIT: if (vcnt == front_tgt_q) state_nx = ST_COPY;
      ST_COPY: if (left == PTR_W'(1)) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (CLR) state_nx = ST_IDLE;
  end

  // Each counted sample re-aims rd_ptr so the last one leaves it at the
  // oldest entry of the window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vcnt        <= '0;
      front_tgt_q <= '0;
      win_len_q   <= '0;
      rd_ptr      <= '0;
      left        <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
    end else if (!CLR) begin
      case (state)
        ST_IDLE: if (STRB) begin
          front_tgt_q <= front_tgt_in;
          win_len_q   <= win_len_in;
          left        <= win_len_in;
          exp_q       <= EXP_DATA;
          mask_q      <= MASK;
          mode_q      <= MODE;
          vcnt        <= {{(PTR_W-1){1'b0}}, DQ_VALID};
          if (DQ_VALID) rd_ptr <= wp + PTR_W'(1) - win_len_in;
        end
        ST_WAIT: if (DQ_VALID && vcnt != front_tgt_q) begin
          vcnt   <= vcnt + 1'b1;
          rd_ptr <= wp + PTR_W'(1) - win_len_q;
        end
        ST_COPY: begin
          rd_ptr <= rd_ptr + 1'b1;
          left   <= left - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign push      = (state == ST_COPY) && !CLR;
  assign pop       = RD_EN && !CLR;
  assign push_data = hist[rd_ptr];
  assign mismatch  = push && mode_q && (((push_data ^ exp_q) & mask_q) != '0);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      OVF       <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_CNT  <= '0;
      STRB_MISS <= 1'b0;
    end else begin
      if (STRB && state != ST_IDLE) STRB_MISS <= 1'b1;
      if (push && fifo_full && !(pop && !fifo_empty)) OVF <= 1'b1;
      if (mismatch) begin
        FAIL <= 1'b1;
        if (FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + 1'b1;
      end
    end
  end

  ate_cap_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .clr       (CLR),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (RD_DATA),
    .pop_valid (RD_VALID),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (SAMP_CNT)
  );

  assign BUSY      = (state != ST_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_ate_strobe_capture.sv
// Directed bench for ate_strobe_capture: window placement, pre-reset zeros,
// overflow, masked compare, missed strobes, clear and gapped valids.
`timescale 1ns/1ps
module tb_ate_strobe_capture;
  import ate_strobe_capture_pkg::*;

  localparam int DATA_W    = 8;
  localparam int WIN_W     = 5;
  localparam int BUF_DEPTH = 32;
  localparam int CNT_W     = 6;

  logic              CLK = 1'b0;
  logic              RST;
  logic [DATA_W-1:0] DQ;
  logic              DQ_VALID;
  logic              STRB;
  logic [WIN_W-1:0]  STRB_BACK;
  logic [WIN_W-1:0]  STRB_FRONT;
  logic              MODE;
  logic [DATA_W-1:0] EXP_DATA;
  logic [DATA_W-1:0] MASK;
  logic              CLR;
  logic              RD_EN;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              BUSY;
  logic [CNT_W-1:0]  SAMP_CNT;
  logic              OVF;
  logic              FAIL;
  logic              STRB_MISS;
  logic [15:0]       FAIL_CNT;
  cap_state_e        DBG_STATE;

  int checks   = 0;
  int failures = 0;
  int wait_obs = 0;
  int copy_obs = 0;
  logic [DATA_W-1:0] exp_q[$];

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  ate_strobe_capture #(
    .DATA_W    (DATA_W),
    .WIN_W     (WIN_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DQ         (DQ),
    .DQ_VALID   (DQ_VALID),
    .STRB       (STRB),
    .STRB_BACK  (STRB_BACK),
    .STRB_FRONT (STRB_FRONT),
    .MODE       (MODE),
    .EXP_DATA   (EXP_DATA),
    .MASK       (MASK),
    .CLR        (CLR),
    .RD_EN      (RD_EN),
    .RD_DATA    (RD_DATA),
    .RD_VALID   (RD_VALID),
    .BUSY       (BUSY),
    .SAMP_CNT   (SAMP_CNT),
    .OVF        (OVF),
    .FAIL       (FAIL),
    .STRB_MISS  (STRB_MISS),
    .FAIL_CNT   (FAIL_CNT),
    .DBG_STATE  (DBG_STATE)
  );

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
    if (DBG_STATE == ST_WAIT) wait_obs++;
    if (DBG_STATE == ST_COPY) copy_obs++;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic s);
    DQ_VALID = v;
    DQ       = d;
    STRB     = s;
    tick();
    DQ_VALID = 1'b0;
    STRB     = 1'b0;
  endtask

  task automatic do_reset();
    DQ = '0; DQ_VALID = 0; STRB = 0; STRB_BACK = '0; STRB_FRONT = '0;
    MODE = 0; EXP_DATA = '0; MASK = '0; CLR = 0; RD_EN = 0;
    RST = 1;
    tick();
    tick();
    RST = 0;
    wait_obs = 0;
    copy_obs = 0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b want=0", tag, BUSY);
    end
  endtask

  // scoreboard: pop every expected entry, then probe an empty read
  task automatic drain_compare(input string tag);
    int n;
    n = exp_q.size();
    RD_EN = 1;
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (RD_VALID !== 1'b1 || RD_DATA !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_entry%0d got=%h valid=%b want=%h", tag, k, RD_DATA, RD_VALID, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    tick();
    RD_EN = 0;
    checks++;
    if (RD_VALID !== 1'b0 || SAMP_CNT !== '0) begin
      failures++;
      $display("FAIL %s_empty_read valid=%b cnt=%0d want valid=0 cnt=0", tag, RD_VALID, SAMP_CNT);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (RD_DATA !== 8'h00 || RD_VALID !== 1'b0 || BUSY !== 1'b0 || SAMP_CNT !== 6'd0 ||
        DBG_STATE !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_datapath rd=%h v=%b busy=%b cnt=%0d st=%0d want 0", RD_DATA, RD_VALID,
               BUSY, SAMP_CNT, DBG_STATE);
    end
    checks++;
    if (OVF !== 1'b0 || FAIL !== 1'b0 || STRB_MISS !== 1'b0 || FAIL_CNT !== 16'd0) begin
      failures++;
      $display("FAIL reset_flags ovf=%b fail=%b miss=%b fcnt=%0d want 0", OVF, FAIL, STRB_MISS, FAIL_CNT);
    end
    // reset in the middle of a window must drop it
    STRB_BACK = 5'd3; STRB_FRONT = 5'd2;
    drive(1, 8'h11, 1);
    drive(1, 8'h12, 0);
    RST = 1;
    tick();
    RST = 0;
    for (int k = 0; k < 10; k++) drive(1, 8'h20 + 8'(k), 0);
    checks++;
    if (BUSY !== 1'b0 || SAMP_CNT !== 6'd0) begin
      failures++;
      $display("FAIL reset_mid_window busy=%b cnt=%0d want busy=0 cnt=0", BUSY, SAMP_CNT);
    end
  endtask

  task automatic test_window();
    do_reset();
    STRB_BACK = 5'd2; STRB_FRONT = 5'd3;
    for (int d = 1; d <= 20; d++) drive(1, 8'(d), d == 10);
    wait_idle("window");
    checks++;
    if (wait_obs != 4 || copy_obs != 6) begin
      failures++;
      $display("FAIL window_busy wait=%0d copy=%0d want wait=4 copy=6", wait_obs, copy_obs);
    end
    checks++;
    if (SAMP_CNT !== 6'd6) begin
      failures++;
      $display("FAIL window_count got=%0d want=6", SAMP_CNT);
    end
    for (int d = 8; d <= 13; d++) exp_q.push_back(8'(d));
    drain_compare("window");
  endtask

  task automatic test_pre_reset();
    do_reset();
    STRB_BACK = 5'd5; STRB_FRONT = 5'd0;
    drive(1, 8'h31, 0);
    drive(1, 8'h32, 1);
    wait_idle("prereset");
    checks++;
    if (SAMP_CNT !== 6'd6) begin
      failures++;
      $display("FAIL prereset_count got=%0d want=6", SAMP_CNT);
    end
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h31, 8'h32};
    drain_compare("prereset");
  endtask

  task automatic test_overflow();
    do_reset();
    STRB_BACK = 5'd15; STRB_FRONT = 5'd15;
    for (int d = 1; d <= 140; d++) drive(1, 8'(d), (d == 20) || (d == 80));
    wait_idle("ovf");
    checks++;
    if (SAMP_CNT !== 6'd32 || OVF !== 1'b1 || STRB_MISS !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flags cnt=%0d ovf=%b miss=%b want cnt=32 ovf=1 miss=0", SAMP_CNT, OVF, STRB_MISS);
    end
    for (int d = 5; d <= 35; d++) exp_q.push_back(8'(d));
    exp_q.push_back(8'd65);
    // single-entry window pushed while full, popped in the same cycle
    STRB_BACK = 5'd0; STRB_FRONT = 5'd0;
    drive(1, 8'hC8, 1);
    drive(0, 8'h00, 0);
    checks++;
    if (DBG_STATE !== ST_COPY) begin
      failures++;
      $display("FAIL ovf_copy_state got=%0d want=%0d", DBG_STATE, ST_COPY);
    end
    RD_EN = 1;
    tick();
    RD_EN = 0;
    checks++;
    if (RD_VALID !== 1'b1 || RD_DATA !== exp_q[0] || SAMP_CNT !== 6'd32) begin
      failures++;
      $display("FAIL ovf_push_pop_full rd=%h v=%b cnt=%0d want rd=%h v=1 cnt=32", RD_DATA, RD_VALID,
               SAMP_CNT, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(8'hC8);
    drain_compare("ovf");
  endtask

  task automatic test_compare();
    do_reset();
    MODE = 1; EXP_DATA = 8'hA5; MASK = 8'hF0;
    STRB_BACK = 5'd2; STRB_FRONT = 5'd0;
    drive(1, 8'hA0, 0);
    drive(1, 8'hA5, 0);
    drive(1, 8'hB5, 1);
    wait_idle("cmp");
    checks++;
    if (FAIL !== 1'b1 || FAIL_CNT !== 16'd1) begin
      failures++;
      $display("FAIL cmp_result fail=%b fcnt=%0d want fail=1 fcnt=1", FAIL, FAIL_CNT);
    end
    exp_q = '{8'hA0, 8'hA5, 8'hB5};
    drain_compare("cmp");
    CLR = 1;
    tick();
    CLR = 0;
    checks++;
    if (FAIL !== 1'b0 || FAIL_CNT !== 16'd0) begin
      failures++;
      $display("FAIL cmp_clr fail=%b fcnt=%0d want 0", FAIL, FAIL_CNT);
    end
    // capture-only mode never flags mismatches
    MODE = 0; STRB_BACK = 5'd0;
    drive(1, 8'h00, 1);
    wait_idle("cmp_mode0");
    checks++;
    if (FAIL !== 1'b0 || FAIL_CNT !== 16'd0 || SAMP_CNT !== 6'd1) begin
      failures++;
      $display("FAIL cmp_mode0 fail=%b fcnt=%0d cnt=%0d want 0,0,1", FAIL, FAIL_CNT, SAMP_CNT);
    end
    exp_q = '{8'h00};
    drain_compare("cmp_mode0");
  endtask

  task automatic test_strb_miss_clr();
    int n;
    do_reset();
    STRB_BACK = 5'd1; STRB_FRONT = 5'd3;
    for (int d = 1; d <= 20; d++) drive(1, 8'(d), (d == 10) || (d == 12));
    wait_idle("miss");
    checks++;
    if (STRB_MISS !== 1'b1 || SAMP_CNT !== 6'd5) begin
      failures++;
      $display("FAIL miss_flag miss=%b cnt=%0d want miss=1 cnt=5", STRB_MISS, SAMP_CNT);
    end
    for (int d = 9; d <= 13; d++) exp_q.push_back(8'(d));
    drain_compare("miss");
    STRB_BACK = 5'd10; STRB_FRONT = 5'd0;
    drive(1, 8'h50, 1);
    n = 0;
    while (DBG_STATE !== ST_COPY && n < 20) begin
      tick();
      n++;
    end
    tick();
    CLR = 1;
    tick();
    CLR = 0;
    checks++;
    if (DBG_STATE !== ST_IDLE || BUSY !== 1'b0 || SAMP_CNT !== 6'd0 || STRB_MISS !== 1'b0) begin
      failures++;
      $display("FAIL clr_in_copy st=%0d busy=%b cnt=%0d miss=%b want 0", DBG_STATE, BUSY, SAMP_CNT,
               STRB_MISS);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (SAMP_CNT !== 6'd0) begin
      failures++;
      $display("FAIL clr_after cnt=%0d want=0", SAMP_CNT);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    STRB_BACK = 5'd1; STRB_FRONT = 5'd2;
    drive(1, 8'h41, 0);
    drive(1, 8'h42, 1);
    drive(0, 8'hEE, 0);
    drive(1, 8'h43, 0);
    drive(0, 8'hEE, 0);
    drive(1, 8'h44, 0);
    drive(0, 8'hEE, 0);
    drive(1, 8'h45, 0);
    wait_idle("gap");
    checks++;
    if (wait_obs != 5 || copy_obs != 4) begin
      failures++;
      $display("FAIL gap_timing wait=%0d copy=%0d want wait=5 copy=4", wait_obs, copy_obs);
    end
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    drain_compare("gap");
  endtask

  initial begin
    test_reset();
    test_window();
    test_pre_reset();
    test_overflow();
    test_compare();
    test_strb_miss_clr();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
